huffman_decoder: RTL and testbench
==================================

# huffman_decoder

Bit-serial Huffman decoder for the six-symbol alphabet used by the Huffman coding datapath. It consumes the code table produced by the code generator (HC1..HC6 code values, M1..M6 LSB-aligned length masks) and a serial MSB-first bitstream. It emits one decoded symbol index (1..6) per complete codeword through a valid/ready output. It sits downstream of the table generator, and its output is the round-trip check against the encoder's source symbols.

## Interface
- Parameters: none. Widths are fixed by the package: CODE_W=8, SYM_W=3, CNT_W=16.
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-low; clears all state on the rising edge where reset==0.
- load  in  1  table load strobe; captures HC1..HC6/M1..M6 on that edge.
- HC1..HC6  in  8 each  code value, LSB-aligned.
- M1..M6  in  8 each  length mask, contiguous ones from bit 0; code length = popcount.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_in  in  1  next stream bit; first bit is the code MSB.
- bit_ready  out  1  decoder accepts a bit this cycle.
- sym_valid  out  1  sym holds a decoded symbol.
- sym  out  3  symbol index 1..6.
- out_ready  in  1  consumer takes sym this cycle.
- err  out  1  one-cycle pulse: 8 bits accumulated with no match.
- sym_cnt  out  16  decoded-symbol count since reset/load; wraps at 65535 to 0.

## Operation
- FSM states: NOTAB, ACCUM, HOLD.
  - NOTAB: reset state; bit_ready=0. load -> ACCUM.
  - ACCUM: bit_ready=1. An accepted bit (bit_valid&bit_ready) shifts into cur: cur<={cur[6:0],bit_in}, len<=len+1, msk<={msk[6:0],1}.
  - Match condition for entry i, evaluated on the post-shift value: {cur[6:0],bit_in}==HC_i and {msk[6:0],1}==M_i, with M_i nonzero.
  - On a match: sym<=i, sym_valid<=1, cur/len/msk<=0, sym_cnt++.
  - Priority on multiple matches (illegal, non-prefix-free table): lowest i wins.
  - No match and new len==8: err pulses, accumulator clears, no symbol, state stays ACCUM.
  - HOLD: entered while sym_valid==1. bit_ready=out_ready.
  - In HOLD, an accepted bit starts the next code in the same cycle the symbol pops.
  - In HOLD, sym_valid stays 1 until out_ready. If the bit completes a 1-bit code in that cycle, sym is replaced and sym_valid stays 1; otherwise sym_valid<=0 and state returns to ACCUM.
- load in ACCUM/HOLD: tables recaptured; accumulator, sym_valid and sym_cnt cleared; state ACCUM. load has priority over a same-cycle bit, and that bit is not consumed.
- reset (low) has priority over everything.

## Timing
- Reset values: bit_ready=0, sym_valid=0, sym=0, err=0, sym_cnt=0. Internal: cur=0, len=0, msk=0, state NOTAB.
- Latency: the last bit of a codeword accepted at edge k gives sym_valid=1 from edge k (visible in cycle k+1).
- Throughput: one bit per cycle, sustained while out_ready=1.
- bit_ready is combinational from state and out_ready only. There is no path from bit_valid to bit_ready.
- A held symbol's sym and sym_valid are stable until out_ready.
- err is registered and high for exactly one cycle.

## Structure
- huffman_pkg:
  - CODE_W=8, SYM_W=3, CNT_W=16, NSYM=6.
  - state enum {NOTAB, ACCUM, HOLD}.
  - Table entry typedef {code[7:0], mask[7:0]}.
- Sub-module huffman_match: combinational; takes 6 table entries plus candidate cur/msk, returns hit and lowest-index sym. Reused by the encoder bench checker.
- Top holds the table registers, the accumulator, the FSM, the output register and the counter.

## Test plan
Table T: HC1=00 M1=01; HC2=02 M2=03; HC3=06 M3=07; HC4=0E M4=0F; HC5=1E M5=1F; HC6=1F M6=1F.
- Reset low 2 cycles, then no load, bit_valid=1 -> bit_ready=0, sym_valid=0, sym_cnt=0.
- Load T, stream 0,1,0,1,1,1,1,1 with out_ready=1 -> syms 1,2,6 at cycles 1,3,8 after the first bit; sym_cnt=3.
- Load T, out_ready=0 after "110" -> sym=3 held, bit_ready=0; raise out_ready with bit 0 -> sym 3 pops, then sym=1 valid the next cycle.
- Load a table with M6=0 and no other code of 11111; stream 1,1,1,1,1,1,1,1 -> err pulse once after the 8th bit, no symbol, sym_cnt unchanged.
- Mid-code load after "11" -> sym_valid=0, sym_cnt=0; stream "0" -> sym=1.
- Decode 65536 symbol-1 codes -> sym_cnt wraps to 0; reset low mid-code -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/huffman_pkg.sv
// huffman_pkg
// Shared widths, FSM state encoding and code-table entry type for the
// bit-serial Huffman decoder and its combinational table matcher.
package huffman_pkg;

    localparam int CODE_W = 8;
    localparam int SYM_W  = 3;
    localparam int CNT_W  = 16;
    localparam int NSYM   = 6;
    localparam int LEN_W  = 4;   // holds 0..CODE_W accumulated bits

    typedef enum logic [1:0] {
        NOTAB = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [CODE_W-1:0] mask;
    } huff_entry_t;

endpackage

// File: rtl/huffman_match.sv
// huffman_match
// Combinational lookup of a candidate code (value + LSB-aligned length mask)
// against the six-entry code table. Entries with an all-zero mask are
// disabled. If the table is not prefix-free and several entries hit, the
// lowest-index entry wins.
// Ports:
//   i_tab  table entries, index 0 holds symbol 1
//   i_cur  candidate code value, LSB-aligned
//   i_msk  candidate length mask, LSB-aligned
//   o_hit  some enabled entry matches
//   o_sym  matching symbol index 1..6 (0 when no hit)
module huffman_match
    import huffman_pkg::*;
(
    input  huff_entry_t [NSYM-1:0] i_tab,
    input  logic [CODE_W-1:0]      i_cur,
    input  logic [CODE_W-1:0]      i_msk,
    output logic                   o_hit,
    output logic [SYM_W-1:0]       o_sym
);

    // Scan from the highest index down so the lowest matching index is the
    // last assignment and therefore wins.
    always_comb begin
        o_hit = 1'b0;
        o_sym = '0;
        for (int i = NSYM - 1; i >= 0; i--) begin
            if ((i_tab[i].mask != '0) &&
                (i_tab[i].code == i_cur) &&
                (i_tab[i].mask == i_msk)) begin
                o_hit = 1'b1;
                o_sym = SYM_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/huffman_decoder.sv
// huffman_decoder
// Bit-serial, MSB-first Huffman decoder for a six-symbol alphabet. Bits are
// shifted into an accumulator; after every accepted bit the post-shift code is
// matched against the loaded table and a hit emits the symbol index on a
// valid/ready output. Eight bits with no hit raise a one-cycle err pulse.
// Ports:
//   clk        clock, all state on rising edge
//   reset      synchronous active-low reset
//   load       capture HC1..HC6 / M1..M6 and restart decoding
//   HC1..HC6   code values, LSB-aligned
//   M1..M6     length masks, contiguous ones from bit 0
//   bit_valid  bit_in is valid this cycle
//   bit_in     next stream bit (code MSB first)
//   bit_ready  decoder accepts a bit this cycle
//   sym_valid  sym holds a decoded symbol
//   sym        decoded symbol index 1..6
//   out_ready  consumer takes sym this cycle
//   err        one-cycle pulse: 8 bits without a match
//   sym_cnt    decoded-symbol count since reset/load, wrapping
//
// state | meaning
// NOTAB | no table loaded yet, no bits accepted
// ACCUM | accumulating bits, no symbol pending
// HOLD  | symbol pending on the output until out_ready
module huffman_decoder
    import huffman_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [CODE_W-1:0] HC1,
    input  logic [CODE_W-1:0] HC2,
    input  logic [CODE_W-1:0] HC3,
    input  logic [CODE_W-1:0] HC4,
    input  logic [CODE_W-1:0] HC5,
    input  logic [CODE_W-1:0] HC6,
    input  logic [CODE_W-1:0] M1,
    input  logic [CODE_W-1:0] M2,
    input  logic [CODE_W-1:0] M3,
    input  logic [CODE_W-1:0] M4,
    input  logic [CODE_W-1:0] M5,
    input  logic [CODE_W-1:0] M6,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              bit_ready,
    output logic              sym_valid,
    output logic [SYM_W-1:0]  sym,
    input  logic              out_ready,
    output logic              err,
    output logic [CNT_W-1:0]  sym_cnt
);

    state_t                  r_state, w_state_nx;
    huff_entry_t [NSYM-1:0]  r_tab, w_tab_nx, w_tab_in;
    logic [CODE_W-1:0]       r_cur, w_cur_nx, w_cur_sh;
    logic [CODE_W-1:0]       r_msk, w_msk_nx, w_msk_sh;
    logic [LEN_W-1:0]        r_len, w_len_nx, w_len_sh;
    logic                    r_sv, w_sv_nx;
    logic [SYM_W-1:0]        r_sym, w_sym_nx;
    logic                    r_err, w_err_nx;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nx;
    logic                    w_accept;
    logic                    w_hit;
    logic [SYM_W-1:0]        w_sym;

    assign w_tab_in[0] = '{code: HC1, mask: M1};
    assign w_tab_in[1] = '{code: HC2, mask: M2};
    assign w_tab_in[2] = '{code: HC3, mask: M3};
    assign w_tab_in[3] = '{code: HC4, mask: M4};
    assign w_tab_in[4] = '{code: HC5, mask: M5};
    assign w_tab_in[5] = '{code: HC6, mask: M6};

    // bit_ready depends only on state and out_ready: a pending symbol must
    // pop in the same cycle a new bit is taken.
    assign bit_ready = (r_state == ACCUM) || ((r_state == HOLD) && out_ready);
    assign w_accept  = bit_valid && bit_ready;

    assign w_cur_sh = {r_cur[CODE_W-2:0], bit_in};
    assign w_msk_sh = {r_msk[CODE_W-2:0], 1'b1};
    assign w_len_sh = r_len + LEN_W'(1);

    huffman_match u_match (
        .i_tab (r_tab),
        .i_cur (w_cur_sh),
        .i_msk (w_msk_sh),
        .o_hit (w_hit),
        .o_sym (w_sym)
    );

    always_comb begin
        w_state_nx = r_state;
        w_tab_nx   = r_tab;
        w_cur_nx   = r_cur;
        w_msk_nx   = r_msk;
        w_len_nx   = r_len;
        w_sv_nx    = r_sv;
        w_sym_nx   = r_sym;
        w_err_nx   = 1'b0;
        w_cnt_nx   = r_cnt;

        if (load) begin
            // load wins over a same-cycle bit; that bit is dropped
            w_tab_nx   = w_tab_in;
            w_cur_nx   = '0;
            w_msk_nx   = '0;
            w_len_nx   = '0;
            w_sv_nx    = 1'b0;
            w_cnt_nx   = '0;
            w_state_nx = ACCUM;
        end else begin
            if ((r_state == HOLD) && out_ready) begin
                w_sv_nx    = 1'b0;
                w_state_nx = ACCUM;
            end
            if (w_accept) begin
                if (w_hit) begin
                    w_sym_nx   = w_sym;
                    w_sv_nx    = 1'b1;
                    w_cur_nx   = '0;
                    w_msk_nx   = '0;
                    w_len_nx   = '0;
                    w_cnt_nx   = r_cnt + CNT_W'(1);
                    w_state_nx = HOLD;
                end else if (w_len_sh == LEN_W'(CODE_W)) begin
                    w_err_nx = 1'b1;
                    w_cur_nx = '0;
                    w_msk_nx = '0;
                    w_len_nx = '0;
                end else begin
                    w_cur_nx = w_cur_sh;
                    w_msk_nx = w_msk_sh;
                    w_len_nx = w_len_sh;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= NOTAB;
            r_tab   <= '0;
            r_cur   <= '0;
            r_msk   <= '0;
            r_len   <= '0;
            r_sv    <= 1'b0;
            r_sym   <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_tab   <= w_tab_nx;
            r_cur   <= w_cur_nx;
            r_msk   <= w_msk_nx;
            r_len   <= w_len_nx;
            r_sv    <= w_sv_nx;
            r_sym   <= w_sym_nx;
            r_err   <= w_err_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    assign sym_valid = r_sv;
    assign sym       = r_sym;
    assign err       = r_err;
    assign sym_cnt   = r_cnt;

endmodule

// File: tb/tb_huffman_decoder.sv
// tb_huffman_decoder
// Directed bench for huffman_decoder: reset, streaming decode, output
// back-pressure, error pulse, mid-code reload, counter wrap, mid-code reset.
module tb_huffman_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [7:0]  HC1, HC2, HC3, HC4, HC5, HC6;
    logic [7:0]  M1, M2, M3, M4, M5, M6;
    logic        bit_valid;
    logic        bit_in;
    logic        bit_ready;
    logic        sym_valid;
    logic [2:0]  sym;
    logic        out_ready;
    logic        err;
    logic [15:0] sym_cnt;

    int checks = 0;
    int errors = 0;

    huffman_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .HC1       (HC1),
        .HC2       (HC2),
        .HC3       (HC3),
        .HC4       (HC4),
        .HC5       (HC5),
        .HC6       (HC6),
        .M1        (M1),
        .M2        (M2),
        .M3        (M3),
        .M4        (M4),
        .M5        (M5),
        .M6        (M6),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .bit_ready (bit_ready),
        .sym_valid (sym_valid),
        .sym       (sym),
        .out_ready (out_ready),
        .err       (err),
        .sym_cnt   (sym_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
    endtask

    // Table T, with a selectable M6 so one entry can be disabled.
    task automatic load_t(input logic [7:0] m6);
        HC1 = 8'h00; M1 = 8'h01;
        HC2 = 8'h02; M2 = 8'h03;
        HC3 = 8'h06; M3 = 8'h07;
        HC4 = 8'h0E; M4 = 8'h0F;
        HC5 = 8'h1E; M5 = 8'h1F;
        HC6 = 8'h1F; M6 = m6;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    logic [7:0] s2;
    int         exp_sym2 [8] = '{1, 0, 2, 0, 0, 0, 0, 6};

    initial begin
        reset = 1'b0; load = 1'b0; bit_valid = 1'b1; bit_in = 1'b0; out_ready = 1'b1;
        HC1 = '0; HC2 = '0; HC3 = '0; HC4 = '0; HC5 = '0; HC6 = '0;
        M1 = '0; M2 = '0; M3 = '0; M4 = '0; M5 = '0; M6 = '0;

        // reset held low two cycles, then released with no load
        tick();
        tick();
        chk("rst_bit_ready", 32'(bit_ready), 32'd0);
        chk("rst_sym_valid", 32'(sym_valid), 32'd0);
        chk("rst_sym", 32'(sym), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cnt", 32'(sym_cnt), 32'd0);
        reset = 1'b1;
        tick();
        chk("notab_bit_ready", 32'(bit_ready), 32'd0);
        chk("notab_sym_valid", 32'(sym_valid), 32'd0);
        chk("notab_cnt", 32'(sym_cnt), 32'd0);

        // streaming decode: 0 | 10 | 11111 -> 1, 2, 6
        bit_valid = 1'b0;
        load_t(8'h1F);
        chk("acc_bit_ready", 32'(bit_ready), 32'd1);
        s2 = 8'b0101_1111;
        for (int i = 0; i < 8; i++) begin
            send_bit(s2[7-i]);
            chk($sformatf("stream_sv_%0d", i), 32'(sym_valid), 32'(exp_sym2[i] != 0));
            if (exp_sym2[i] != 0)
                chk($sformatf("stream_sym_%0d", i), 32'(sym), 32'(exp_sym2[i]));
        end
        bit_valid = 1'b0;
        chk("stream_cnt", 32'(sym_cnt), 32'd3);
        tick();
        chk("stream_pop", 32'(sym_valid), 32'd0);

        // back-pressure: "110" held, then popped together with a 1-bit code
        out_ready = 1'b0;
        load_t(8'h1F);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("hold_sv", 32'(sym_valid), 32'd1);
        chk("hold_sym", 32'(sym), 32'd3);
        chk("hold_cnt", 32'(sym_cnt), 32'd1);
        chk("hold_bit_ready", 32'(bit_ready), 32'd0);
        send_bit(1'b0);
        chk("hold_stable_sv", 32'(sym_valid), 32'd1);
        chk("hold_stable_sym", 32'(sym), 32'd3);
        chk("hold_stable_cnt", 32'(sym_cnt), 32'd1);
        out_ready = 1'b1;
        #1;
        chk("hold_ready_up", 32'(bit_ready), 32'd1);
        send_bit(1'b0);
        chk("replace_sv", 32'(sym_valid), 32'd1);
        chk("replace_sym", 32'(sym), 32'd1);
        chk("replace_cnt", 32'(sym_cnt), 32'd2);
        bit_valid = 1'b0;
        tick();
        chk("replace_pop", 32'(sym_valid), 32'd0);

        // 8 ones with entry 6 disabled -> single err pulse, no symbol
        load_t(8'h00);
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1);
            chk($sformatf("err_pulse_%0d", i), 32'(err), 32'(i == 7));
            chk($sformatf("err_sv_%0d", i), 32'(sym_valid), 32'd0);
        end
        bit_valid = 1'b0;
        tick();
        chk("err_drop", 32'(err), 32'd0);
        chk("err_cnt", 32'(sym_cnt), 32'd0);

        // mid-code reload after "11"; the same-cycle bit must be dropped
        load_t(8'h1F);
        send_bit(1'b0);
        chk("mid_pre_sv", 32'(sym_valid), 32'd1);
        chk("mid_pre_cnt", 32'(sym_cnt), 32'd1);
        send_bit(1'b1);
        send_bit(1'b1);
        chk("mid_acc_sv", 32'(sym_valid), 32'd0);
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        load_t(8'h1F);
        chk("mid_load_sv", 32'(sym_valid), 32'd0);
        chk("mid_load_cnt", 32'(sym_cnt), 32'd0);
        send_bit(1'b0);
        chk("mid_after_sv", 32'(sym_valid), 32'd1);
        chk("mid_after_sym", 32'(sym), 32'd1);
        chk("mid_after_cnt", 32'(sym_cnt), 32'd1);

        // counter wrap
        load_t(8'h1F);
        for (int i = 0; i < 65535; i++)
            send_bit(1'b0);
        chk("wrap_max", 32'(sym_cnt), 32'hFFFF);
        send_bit(1'b0);
        chk("wrap_zero", 32'(sym_cnt), 32'd0);
        chk("wrap_sv", 32'(sym_valid), 32'd1);
        chk("wrap_sym", 32'(sym), 32'd1);

        // reset in the middle of a code
        send_bit(1'b1);
        chk("pre_rst_sv", 32'(sym_valid), 32'd0);
        reset = 1'b0;
        tick();
        chk("mrst_bit_ready", 32'(bit_ready), 32'd0);
        chk("mrst_sv", 32'(sym_valid), 32'd0);
        chk("mrst_sym", 32'(sym), 32'd0);
        chk("mrst_err", 32'(err), 32'd0);
        chk("mrst_cnt", 32'(sym_cnt), 32'd0);
        reset = 1'b1;
        bit_valid = 1'b0;
        tick();
        chk("mrst_notab", 32'(bit_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
